// File: rtl/lisa_pkg.sv
// Shared LISA fetch definitions: sequencer state, word/address geometry,
// and the instruction length legality rule.
package lisa_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   localparam int unsigned LISA_WORD_BYTES = 4;
   localparam int unsigned LISA_AW         = 32;

   function automatic logic len_ok(input logic [7:0] len, input int unsigned max_bytes);
      return (len >= 8'd2) && (32'(len) <= max_bytes);
   endfunction

endpackage

// File: rtl/lisa_fetch_unit.sv
// Decodes the queue head window: opcode, total length and length legality.
module lisa_fetch_unit
   import lisa_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 16
)(
   input  logic [MAX_BYTES*8-1:0] window,
   output logic [7:0]             opcode,
   output logic [7:0]             len,
   output logic                   len_valid
);

   assign opcode    = window[7:0];
   assign len       = window[15:8];
   assign len_valid = len_ok(len, MAX_BYTES);

endmodule

// File: rtl/lisa_fetch_sequencer.sv
// Instruction fetch sequencer: word reads into a byte queue, variable-length
// instruction handoff, redirects and malformed-length fault halt.
module lisa_fetch_sequencer
   import lisa_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 16,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   output logic                   mem_req,
   output logic [31:0]            mem_addr,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [31:0]            mem_rdata,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [MAX_BYTES*8-1:0] inst_bytes,
   output logic [7:0]             inst_opcode,
   output logic [7:0]             inst_len,
   output logic [31:0]            inst_pc,
   output logic                   fetch_fault
);

   localparam int unsigned QB = MAX_BYTES + LISA_WORD_BYTES;

   fetch_state_t         state, state_next;
   logic [QB*8-1:0]      q, q_next, q_sh;
   logic [7:0]           count, count_next, count_sh, shift;
   logic [LISA_AW-1:0]   fpc, fpc_next, pc, pc_next;
   logic [1:0]           skip, skip_next;
   logic                 outstanding, out_next, drop, drop_next;
   logic                 len_valid, fault_now, fault_next, accept, beat_take, issue;
   logic [31:0]          beat;
   logic [2:0]           beat_n;

   lisa_fetch_unit #(.MAX_BYTES(MAX_BYTES)) u_fetch_unit (
      .window    (q[MAX_BYTES*8-1:0]),
      .opcode    (inst_opcode),
      .len       (inst_len),
      .len_valid (len_valid)
   );

   assign fault_now   = (state == RUN) && (count >= 8'd2) && !len_valid;
   assign inst_valid  = (state == RUN) && (count >= 8'd2) && len_valid && (count >= inst_len);
   assign fetch_fault = (state == FAULT) || fault_now;
   assign inst_bytes  = q[MAX_BYTES*8-1:0];
   assign inst_pc     = pc;
   assign accept      = inst_valid && inst_ready;
   assign beat_take   = mem_rvalid && !drop;

   always_comb begin
      shift      = accept ? inst_len : 8'd0;
      q_sh       = q >> {shift, 3'b000};
      count_sh   = count - shift;
      beat       = mem_rdata >> {skip, 3'b000};
      beat_n     = 3'd4 - {1'b0, skip};
      q_next     = q_sh;
      count_next = count_sh;
      // Append lands after the post-shift occupancy so accept and refill can share a cycle.
      if (beat_take) begin
         for (int unsigned i = 0; i < LISA_WORD_BYTES; i++) begin
            if ((i < 32'(beat_n)) && ((32'(count_sh) + i) < QB))
               q_next[8*(32'(count_sh)+i) +: 8] = beat[8*i +: 8];
         end
         count_next = count_sh + {5'd0, beat_n};
      end

      out_next   = (outstanding && !mem_rvalid) || (mem_req && mem_gnt);
      drop_next  = drop && !mem_rvalid;
      skip_next  = beat_take ? 2'd0 : skip;
      fpc_next   = (mem_req && mem_gnt) ? fpc + 32'd4 : fpc;
      pc_next    = accept ? pc + {24'd0, inst_len} : pc;
      state_next = fault_now ? FAULT : state;

      if (redirect_valid) begin
         q_next     = '0;
         count_next = '0;
         pc_next    = redirect_pc;
         fpc_next   = {redirect_pc[31:2], 2'b00};
         skip_next  = redirect_pc[1:0];
         drop_next  = out_next;
         state_next = RUN;
      end

      // Look ahead at the next head so a request is never raised into a fault.
      fault_next = (count_next >= 8'd2) && !len_ok(q_next[15:8], MAX_BYTES);
      issue      = (state_next == RUN) && !fault_next && !out_next &&
                   (count_next <= 8'(MAX_BYTES));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         q           <= '0;
         count       <= '0;
         fpc         <= {RESET_PC[31:2], 2'b00};
         skip        <= RESET_PC[1:0];
         pc          <= RESET_PC;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
      end else begin
         state       <= state_next;
         q           <= q_next;
         count       <= count_next;
         fpc         <= fpc_next;
         skip        <= skip_next;
         pc          <= pc_next;
         outstanding <= out_next;
         drop        <= drop_next;
         mem_req     <= issue;
         if (issue)
            mem_addr <= fpc_next;
      end
   end

endmodule

// File: tb/tb_lisa_fetch_sequencer.sv
// Directed self-checking bench for lisa_fetch_sequencer with a simple
// one-outstanding memory responder of programmable read latency.
module tb_lisa_fetch_sequencer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         redirect_valid;
   logic [31:0]  redirect_pc;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_gnt;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic         inst_valid;
   logic         inst_ready;
   logic [127:0] inst_bytes;
   logic [7:0]   inst_opcode;
   logic [7:0]   inst_len;
   logic [31:0]  inst_pc;
   logic         fetch_fault;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:1023];
   int          rv_delay = 0;
   int          beats = 0;
   logic        pend;
   logic [31:0] pend_addr, gnt_addr;
   int          pend_dly;

   always #5 clk = ~clk;

   lisa_fetch_sequencer #(.MAX_BYTES(16), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_bytes     (inst_bytes),
      .inst_opcode    (inst_opcode),
      .inst_len       (inst_len),
      .inst_pc        (inst_pc),
      .fetch_fault    (fetch_fault)
   );

   // Memory responder: grants any request, returns data rv_delay+1 cycles later.
   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pend = 1'b0;
      pend_addr = '0; gnt_addr = '0; pend_dly = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; pend = 1'b0;
         end else begin
            if (mem_gnt) begin
               pend = 1'b1; pend_addr = gnt_addr; pend_dly = rv_delay;
            end
            mem_rvalid = 1'b0;
            if (pend) begin
               if (pend_dly == 0) begin
                  mem_rvalid = 1'b1;
                  for (int k = 0; k < 4; k++)
                     mem_rdata[8*k +: 8] = mem[(pend_addr + 32'(k)) & 32'd1023];
                  pend = 1'b0;
                  beats++;
               end else begin
                  pend_dly--;
               end
            end
            mem_gnt  = mem_req;
            gnt_addr = mem_addr;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 1024; i++) mem[i] = 8'h02;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      beats = 0;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1; redirect_pc = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      fill_mem();
      rv_delay = 0;
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      tick(); tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
      checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fetch_fault got %b exp 0", fetch_fault); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
   endtask

   task automatic test_aligned_stream();
      logic [7:0]  exp_op   [3] = '{8'hA1, 8'hB2, 8'hC3};
      logic [7:0]  exp_len  [3] = '{8'd3, 8'd2, 8'd4};
      logic [31:0] exp_pc   [3] = '{32'd0, 32'd3, 32'd5};
      logic [31:0] exp_lo   [3] = '{32'h001103A1, 32'h000002B2, 32'h332204C3};
      logic [31:0] exp_mask [3] = '{32'h00FFFFFF, 32'h0000FFFF, 32'hFFFFFFFF};
      logic [7:0]  rec_op  [3];
      logic [7:0]  rec_len [3];
      logic [31:0] rec_pc  [3];
      logic [31:0] rec_lo  [3];
      int n = 0;
      fill_mem();
      mem[0] = 8'hA1; mem[1] = 8'h03; mem[2] = 8'h11; mem[3] = 8'hB2; mem[4] = 8'h02;
      mem[5] = 8'hC3; mem[6] = 8'h04; mem[7] = 8'h22; mem[8] = 8'h33;
      rv_delay = 0;
      do_reset();
      inst_ready = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
      tick();
      checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL resp_cycle got valid=%b req=%b exp 0 0", inst_valid, mem_req); end
      tick();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b exp 1", inst_valid); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL back_to_back_req got req=%b addr=%h exp req=1 addr=4", mem_req, mem_addr); end
      for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
         if (inst_valid) begin
            rec_op[n] = inst_opcode; rec_len[n] = inst_len; rec_pc[n] = inst_pc; rec_lo[n] = inst_bytes[31:0];
            n++;
         end
         tick();
      end
      inst_ready = 1'b0;
      checks++; if (n != 3) begin errors++; $display("FAIL stream_count got %0d exp 3", n); end
      for (int k = 0; k < n; k++) begin
         checks++; if (rec_op[k] !== exp_op[k]) begin errors++; $display("FAIL stream_op%0d got %h exp %h", k, rec_op[k], exp_op[k]); end
         checks++; if (rec_len[k] !== exp_len[k]) begin errors++; $display("FAIL stream_len%0d got %0d exp %0d", k, rec_len[k], exp_len[k]); end
         checks++; if (rec_pc[k] !== exp_pc[k]) begin errors++; $display("FAIL stream_pc%0d got %h exp %h", k, rec_pc[k], exp_pc[k]); end
         checks++; if ((rec_lo[k] & exp_mask[k]) !== exp_lo[k]) begin errors++; $display("FAIL stream_bytes%0d got %h exp %h", k, rec_lo[k] & exp_mask[k], exp_lo[k]); end
      end
   endtask

   task automatic test_unaligned_redirect();
      fill_mem();
      mem[32'h100] = 8'hEE; mem[32'h101] = 8'hEE; mem[32'h102] = 8'hD4; mem[32'h103] = 8'h03;
      mem[32'h104] = 8'h55; mem[32'h105] = 8'h66; mem[32'h106] = 8'h77; mem[32'h107] = 8'h88;
      rv_delay = 0;
      do_reset();
      for (int i = 0; i < 30; i++) tick();
      do_redirect(32'h102);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL unal_req got req=%b addr=%h exp req=1 addr=100", mem_req, mem_addr); end
      checks++; if (inst_pc !== 32'h102 || inst_valid !== 1'b0) begin errors++; $display("FAIL unal_flush got pc=%h valid=%b exp pc=102 valid=0", inst_pc, inst_valid); end
      for (int i = 0; i < 30 && !inst_valid; i++) tick();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL unal_timeout got valid=%b exp 1", inst_valid); end
      checks++; if (inst_opcode !== 8'hD4 || inst_len !== 8'd3 || inst_pc !== 32'h102) begin errors++; $display("FAIL unal_head got op=%h len=%0d pc=%h exp op=d4 len=3 pc=102", inst_opcode, inst_len, inst_pc); end
      checks++; if (inst_bytes[47:0] !== 48'h8877665503D4) begin errors++; $display("FAIL unal_bytes got %h exp 8877665503d4", inst_bytes[47:0]); end
      checks++; if (inst_bytes[127:48] !== 80'h0) begin errors++; $display("FAIL unal_zero_tail got %h exp 0", inst_bytes[127:48]); end
   endtask

   task automatic test_max_length();
      logic [127:0] exp_win;
      fill_mem();
      mem[0] = 8'h5A; mem[1] = 8'h10;
      for (int i = 2; i < 16; i++) mem[i] = 8'(i);
      for (int i = 0; i < 16; i++) exp_win[8*i +: 8] = mem[i];
      rv_delay = 0;
      do_reset();
      for (int i = 0; i < 60 && !inst_valid; i++) tick();
      checks++; if (inst_valid !== 1'b1 || beats != 4) begin errors++; $display("FAIL max_valid_at got valid=%b beats=%0d exp valid=1 beats=4", inst_valid, beats); end
      checks++; if (inst_len !== 8'd16) begin errors++; $display("FAIL max_len got %0d exp 16", inst_len); end
      checks++; if (inst_bytes !== exp_win) begin errors++; $display("FAIL max_bytes got %h exp %h", inst_bytes, exp_win); end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      for (int i = 0; i < 30 && !(inst_valid && inst_pc == 32'd16); i++) tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd16 || inst_len !== 8'd2) begin errors++; $display("FAIL max_next got valid=%b pc=%h len=%0d exp valid=1 pc=10 len=2", inst_valid, inst_pc, inst_len); end
   endtask

   task automatic test_fault();
      int req_seen = 0;
      fill_mem();
      mem[0] = 8'h77; mem[1] = 8'h01;
      mem[32'h40] = 8'h61; mem[32'h41] = 8'h02;
      rv_delay = 0;
      do_reset();
      inst_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %b exp 1", fetch_fault); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fault_valid got %b exp 0", inst_valid); end
      for (int i = 0; i < 5; i++) begin
         if (mem_req !== 1'b0) req_seen++;
         tick();
      end
      checks++; if (req_seen != 0) begin errors++; $display("FAIL fault_no_req got %0d req cycles exp 0", req_seen); end
      do_redirect(32'h40);
      checks++; if (fetch_fault !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL fault_exit got fault=%b req=%b addr=%h exp 0 1 40", fetch_fault, mem_req, mem_addr); end
      inst_ready = 1'b0;
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      checks++; if (inst_valid !== 1'b1 || inst_opcode !== 8'h61 || inst_pc !== 32'h40) begin errors++; $display("FAIL fault_resume got valid=%b op=%h pc=%h exp 1 61 40", inst_valid, inst_opcode, inst_pc); end
   endtask

   task automatic test_redirect_outstanding();
      fill_mem();
      mem[0] = 8'h99; mem[1] = 8'h05;
      mem[32'h80] = 8'h6C; mem[32'h81] = 8'h02;
      rv_delay = 3;
      do_reset();
      for (int i = 0; i < 10 && !mem_req; i++) tick();
      tick();
      do_redirect(32'h80);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ro_hold_req got %b exp 0", mem_req); end
      for (int i = 0; i < 20 && !mem_req; i++) tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL ro_new_req got req=%b addr=%h exp req=1 addr=80", mem_req, mem_addr); end
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      checks++; if (inst_valid !== 1'b1 || inst_opcode !== 8'h6C || inst_pc !== 32'h80) begin errors++; $display("FAIL ro_head got valid=%b op=%h pc=%h exp 1 6c 80", inst_valid, inst_opcode, inst_pc); end
      checks++; if (inst_bytes[31:0] !== 32'h0202026C) begin errors++; $display("FAIL ro_bytes got %h exp 0202026c", inst_bytes[31:0]); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] snap_bytes, exp_win;
      logic [31:0]  snap_pc;
      logic [7:0]   snap_op, snap_len;
      int unstable = 0;
      int rv_wait = 0;
      fill_mem();
      for (int k = 0; k < 16; k++) begin
         mem[4*k] = 8'h80 + 8'(k); mem[4*k+1] = 8'h04; mem[4*k+2] = 8'(k); mem[4*k+3] = ~8'(k);
      end
      for (int i = 0; i < 16; i++) exp_win[8*i +: 8] = mem[8+i];
      rv_delay = 2;
      do_reset();
      for (int i = 0; i < 60; i++) tick();
      snap_bytes = inst_bytes; snap_pc = inst_pc; snap_op = inst_opcode; snap_len = inst_len;
      checks++; if (inst_valid !== 1'b1 || snap_op !== 8'h80 || snap_pc !== 32'h0) begin errors++; $display("FAIL bp_head got valid=%b op=%h pc=%h exp 1 80 0", inst_valid, snap_op, snap_pc); end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (inst_valid !== 1'b1 || inst_bytes !== snap_bytes || inst_pc !== snap_pc ||
             inst_opcode !== snap_op || inst_len !== snap_len) unstable++;
      end
      checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changed cycles exp 0", unstable); end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      for (rv_wait = 0; rv_wait < 20 && !mem_rvalid; rv_wait++) tick();
      checks++; if (mem_rvalid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL sim_setup got rvalid=%b pc=%h exp rvalid=1 pc=4", mem_rvalid, inst_pc); end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++; if (inst_pc !== 32'h8 || inst_opcode !== 8'h82) begin errors++; $display("FAIL sim_head got pc=%h op=%h exp pc=8 op=82", inst_pc, inst_opcode); end
      checks++; if (inst_bytes !== exp_win) begin errors++; $display("FAIL sim_window got %h exp %h", inst_bytes, exp_win); end
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      test_reset();
      test_aligned_stream();
      test_unaligned_redirect();
      test_max_length();
      test_fault();
      test_redirect_outstanding();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lisa_fetch_sequencer.md
# lisa_fetch_sequencer

Sequences instruction fetch for the LISA core. It issues word reads to instruction memory and packs the returned bytes into a byte queue. It presents the queue head to `lisa_fetch_unit` as a `MAX_BYTES` window and hands each complete variable-length instruction downstream with a valid/ready handshake. It also handles redirects (branch or exception PC) and malformed-length faults.

## Interface
- `MAX_BYTES`, 16: largest legal instruction in bytes; also the width of the decode window.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `redirect_valid` input 1: flush and restart at `redirect_pc`; takes priority over everything else.
- `redirect_pc` input 32: new fetch byte address; may be unaligned.
- `mem_req` output 1: read request; held until granted.
- `mem_addr` output 32: word-aligned address, `[1:0]` is always 0.
- `mem_gnt` input 1: request accepted this cycle.
- `mem_rvalid` input 1: read data valid; one beat per grant, at least one cycle after the grant.
- `mem_rdata` input 32: little-endian, byte at `mem_addr+i` in `[8i+7:8i]`.
- `inst_valid` output 1: a complete instruction is at the queue head.
- `inst_ready` input 1: downstream accepts the instruction.
- `inst_bytes` output MAX_BYTES*8: queue head window; byte 0 is the opcode.
- `inst_opcode` output 8: head byte 0.
- `inst_len` output 8: head byte 1, the total length.
- `inst_pc` output 32: byte address of the head instruction.
- `fetch_fault` output 1: a malformed length was detected; fetch is halted.

## Operation
- The byte queue holds `MAX_BYTES+4` bytes; `count` is its occupancy.
- The fetch pointer `fpc` is word-aligned.
- The drop offset `skip` (2 bits) is the number of low bytes to discard from the next beat after an unaligned redirect.
- States:
  - RUN: the normal fetch state.
  - FAULT: no new requests, `inst_valid`=0, `fetch_fault`=1. The only exit is a redirect.
- RUN → FAULT when `count>=2` and the length is invalid (`inst_len<2` or `inst_len>MAX_BYTES`), as computed by `lisa_fetch_unit`.
- Request issue:
  - Issue only in RUN, with no outstanding read, and `count<=MAX_BYTES`.
  - Raise `mem_req` with `mem_addr=fpc`.
  - On `mem_gnt`, set `outstanding`=1 and `fpc+=4`.
  - At most one read is outstanding.
- Response:
  - On `mem_rvalid`, append bytes `skip..3` of `mem_rdata` at queue position `count`.
  - Then `count += 4-skip` and `skip=0`.
  - If the `drop` flag is set, discard the beat and clear `drop`.
- Handoff:
  - `inst_valid` = RUN && `count>=2` && length valid && `count>=inst_len`.
  - On `inst_valid&&inst_ready`, shift the queue down by `inst_len` bytes and set `inst_pc += inst_len`.
- Simultaneous handoff and response in one cycle: shift and append together. Append position is `count-inst_len`; new count is `count-inst_len+4-skip`.
- Redirect, in the same cycle:
  - `count=0`, `inst_pc=redirect_pc`, `fpc={redirect_pc[31:2],2'b00}`, `skip=redirect_pc[1:0]`, state=RUN.
  - If a read is outstanding, set `drop=1`.
  - Handoffs and responses in the redirect cycle are ignored.
- An ungranted `mem_req` may drop in the redirect cycle. It re-issues next cycle with the new address.
- Address arithmetic wraps modulo 2^32.
- Queue bytes beyond `count` read as 0 in `inst_bytes`.

## Timing
- Reset values (asynchronous):
  - `mem_req`=0, `mem_addr`=0, `inst_valid`=0, `fetch_fault`=0, `inst_pc`=RESET_PC.
  - `count`=0, `outstanding`=0, `drop`=0.
  - `fpc={RESET_PC[31:2],2'b00}`, `skip=RESET_PC[1:0]`, state RUN.
- `mem_req` and `mem_addr` are registered.
  - First `mem_req` goes high in the first cycle after reset release, or the cycle after a redirect.
- `inst_*` outputs and `fetch_fault` are combinational from queue registers only, with no input-to-output paths.
- Latency: with `mem_gnt` in cycle N and `mem_rvalid` in cycle N+1, the bytes are visible in cycle N+2.
- Back-to-back refill: a new request can issue in the cycle after `mem_rvalid`.
- With `inst_valid`=1 and `inst_ready`=0, all `inst_*` outputs stay stable until accept or redirect.
- Reset asserted mid-read: the in-flight beat may still arrive after release and must be discarded. The memory side is reset together with this block, so no such beat occurs.

## Structure
- Shared `lisa_pkg` holds:
  - the state enum `fetch_state_t` {RUN, FAULT};
  - `LISA_WORD_BYTES=4`;
  - the address width constant `LISA_AW=32`.
- One submodule, `lisa_fetch_unit`, is instantiated on the queue head window. It supplies `inst_opcode`, `inst_len` and `len_valid`.
- Queue shifting is a byte-granular barrel shift inside this block.

## Test plan
- **Reset, aligned stream:** `RESET_PC`=0, memory holds `A1 03 xx | B2 02 | C3 04 xx xx` → accepts (A1,len 3,pc 0), (B2,2,pc 3), (C3,4,pc 5) in order, with `inst_ready` tied 1.
- **Unaligned redirect:** `redirect_pc`=0x102 → `mem_addr`=0x100, bytes 0x100–0x101 dropped, first `inst_pc`=0x102.
- **Maximum length:** a 16-byte instruction at 0x0 → `inst_valid` only once `count>=16`, `inst_len`=16, no deadlock.
- **Faults:**
  - head `inst_len`=1 → `fetch_fault`=1, `mem_req` stays 0, `inst_valid`=0;
  - a later redirect to 0x40 clears the fault and fetch resumes.
- **Redirect with a read outstanding:** redirect after `mem_gnt` but before `mem_rvalid` → that beat is discarded and the queue fills only from the redirect target.
- **Backpressure plus a simultaneous event:**
  - hold `inst_ready`=0 for 5 cycles → outputs stable;
  - a cycle with both accept and `mem_rvalid` → count = old−len+4, and byte order is preserved.
